vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Transmit side of the VGA sync interface: generates 640x480@60 Hz timing (Hsync, Vsync)
//  and blanks RGB outside the active region. Clocked by the 25 MHz pixel clock: one pixel
//  per clk cycle, no enable qualifier. Sits between the pixel-colour logic, which reads
//  h_cnt/v_cnt and returns rgb_in, and the top-level vgaRed/Green/Blue, Hsync, Vsync pins.
//  Sync and RGB leave through output flops, one clk behind the counters.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      15   horizontal front porch (pixels)
//  H_SYNC    96   Hsync low width (pixels)
//  H_BP      49   horizontal back porch (pixels); H_TOTAL = sum = 800
//  V_ACTIVE  480  visible lines per frame
//  V_FP      9    vertical front porch (lines)
//  V_SYNC    2    Vsync low width (lines)
//  V_BP      34   vertical back porch (lines); V_TOTAL = sum = 525
//  CW        10   counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//  clk          in   1   pixel clock, 25 MHz, all logic on posedge
//  greset       in   1   synchronous active-high reset
//  rgb_in       in   12  {R[3:0],G[3:0],B[3:0]} for the pixel at the current h_cnt/v_cnt
//  h_cnt        out  CW  current pixel column, 0..H_TOTAL-1 (counter register)
//  v_cnt        out  CW  current line, 0..V_TOTAL-1 (counter register)
//  active       out  1   comb: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
//  line_end     out  1   comb: h_cnt==H_TOTAL-1
//  frame_start  out  1   comb: h_cnt==0 && v_cnt==0
//  Hsync        out  1   registered, active-low horizontal sync
//  Vsync        out  1   registered, active-low vertical sync
//  vgaRed       out  4   registered, blanked red
//  vgaGreen     out  4   registered, blanked green
//  vgaBlue      out  4   registered, blanked blue
// BEHAVIOUR
//  - Reset (greset high at a posedge): h_cnt=0, v_cnt=0, Hsync=1, Vsync=1, RGB outputs=0.
//    Takes effect on the next edge from any state, including mid-line or mid-frame.
//  - h_cnt increments every cycle; at H_TOTAL-1 it wraps to 0.
//  - v_cnt increments only when h_cnt wraps; at V_TOTAL-1 together with h_cnt=H_TOTAL-1,
//    both wrap to 0 on the same edge (simultaneous wrap; frame period 420000 cycles).
//  - Sync decode is comb on the counters and goes through the output flops:
//    hs_n = !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) = !(655..750)
//    vs_n = !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]) = !(489..490)
//    Vsync toggles only at line boundaries (h_cnt=0 of the line), never mid-line.
//  - RGB: outputs <= active ? rgb_in : 12'h000, registered in the same flop stage as the
//    syncs, so RGB and syncs stay aligned at the pins. Latency is 1 cycle from counter to pin.
//  - First edge after reset release: pins reflect (0,0): Hsync=1, Vsync=1, RGB=rgb_in.
//  - No handshake: rgb_in is sampled every cycle and must be valid in the same cycle as its
//    h_cnt/v_cnt. Any pipelining in the colour path is the caller's responsibility.
//  - Counters never take values >= H_TOTAL/V_TOTAL. No other state exists.
// TESTING
//  1 Reset: hold greset 8 cycles, then release -> h_cnt=v_cnt=0, Hsync=Vsync=1, RGB=0
//    while in reset; frame_start=1 on the first cycle after release.
//  2 Hsync: cycle where h_cnt=655 -> Hsync=0 on the next cycle for exactly 96 cycles, high
//    again once h_cnt=751 is registered. Period is 800 cycles over 3 consecutive lines.
//  3 Vsync: v_cnt becomes 489 (h_cnt=0) -> Vsync=0 one cycle later for exactly 1600 cycles.
//    Vsync fall-to-fall is 420000 cycles. Compare against an independent model: 0 mismatches
//    over 2 frames.
//  4 Blanking: rgb_in=12'hFFF constant -> RGB=F/F/F exactly while registered active
//    (640 cycles per visible line) and 0 everywhere else, including v_cnt 480..524.
//  5 Wrap: at h_cnt=799, v_cnt=524 -> next cycle h_cnt=0, v_cnt=0, frame_start=1.
//    At h_cnt=799, v_cnt=100 -> h_cnt=0, v_cnt=101.
//  6 Mid-frame reset: pulse greset 1 cycle at v_cnt=300, h_cnt=700 (Hsync low) -> next cycle
//    counters 0, Hsync=1, RGB=0. Timing then restarts exactly as in scenario 2.

Source files
------------

// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz VGA sync generator: free-running pixel/line counters, active-low
// Hsync/Vsync and blanked 12-bit RGB, all pins driven from one output flop stage.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 15,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 49,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 9,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 34,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          greset,
  input  logic [11:0]   rgb_in,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          active,
  output logic          line_end,
  output logic          frame_start,
  output logic          Hsync,
  output logic          Vsync,
  output logic [3:0]    vgaRed,
  output logic [3:0]    vgaGreen,
  output logic [3:0]    vgaBlue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic          r_hs_n;
  logic          r_vs_n;
  logic [11:0]   r_rgb;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_active;
  logic          w_hs_n;
  logic          w_vs_n;
  logic [11:0]   w_rgb_next;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_active = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_hs_n   = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
  // v_cnt only moves at line wrap, so Vsync can only change at the start of a line.
  assign w_vs_n   = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_blank
      assign w_rgb_next[gi*4 +: 4] = w_active ? rgb_in[gi*4 +: 4] : 4'h0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (greset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hs_n  <= 1'b1;
      r_vs_n  <= 1'b1;
      r_rgb   <= '0;
    end else begin
      r_hs_n <= w_hs_n;
      r_vs_n <= w_vs_n;
      r_rgb  <= w_rgb_next;
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + CW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CW'(1);
      end
    end
  end

  assign h_cnt       = r_h_cnt;
  assign v_cnt       = r_v_cnt;
  assign active      = w_active;
  assign line_end    = w_h_last;
  assign frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign Hsync       = r_hs_n;
  assign Vsync       = r_vs_n;
  assign vgaRed      = r_rgb[11:8];
  assign vgaGreen    = r_rgb[7:4];
  assign vgaBlue     = r_rgb[3:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance for horizontal timing plus a short-frame
// instance (12 lines) so vertical sync and frame wrap are reachable in a short run.
module tb_vga_sync_gen;

  logic        clk    = 1'b0;
  logic        greset = 1'b1;
  logic [11:0] rgb_in = 12'hFFF;
  logic        chk_en = 1'b0;
  logic        rnd_en = 1'b0;

  always #20 clk = ~clk;

  logic [9:0] b_h, b_v, s_h, s_v;
  logic       b_act, b_le, b_fs, b_hs, b_vs;
  logic       s_act, s_le, s_fs, s_hs, s_vs;
  logic [3:0] b_r, b_g, b_b, s_r, s_g, s_b;

  vga_sync_gen u_big (
    .clk(clk), .greset(greset), .rgb_in(rgb_in),
    .h_cnt(b_h), .v_cnt(b_v), .active(b_act), .line_end(b_le), .frame_start(b_fs),
    .Hsync(b_hs), .Vsync(b_vs), .vgaRed(b_r), .vgaGreen(b_g), .vgaBlue(b_b)
  );

  vga_sync_gen #(.V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_small (
    .clk(clk), .greset(greset), .rgb_in(rgb_in),
    .h_cnt(s_h), .v_cnt(s_v), .active(s_act), .line_end(s_le), .frame_start(s_fs),
    .Hsync(s_hs), .Vsync(s_vs), .vgaRed(s_r), .vgaGreen(s_g), .vgaBlue(s_b)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_result(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Reference timing, instance 0 = 640x480 frame, instance 1 = 12-line frame.
  function automatic int v_act(int i); return (i == 0) ? 480 : 6;  endfunction
  function automatic int v_tot(int i); return (i == 0) ? 525 : 12; endfunction
  function automatic int vs_lo(int i); return (i == 0) ? 489 : 8;  endfunction
  function automatic int vs_hi(int i); return (i == 0) ? 490 : 9;  endfunction

  int          m_h[2];
  int          m_v[2];
  logic        m_hs[2];
  logic        m_vs[2];
  logic [11:0] m_rgb[2];
  int          mm[2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (greset) begin
        m_h[i]   <= 0;
        m_v[i]   <= 0;
        m_hs[i]  <= 1'b1;
        m_vs[i]  <= 1'b1;
        m_rgb[i] <= 12'h000;
      end else begin
        m_hs[i]  <= !(m_h[i] >= 655 && m_h[i] <= 750);
        m_vs[i]  <= !(m_v[i] >= vs_lo(i) && m_v[i] <= vs_hi(i));
        m_rgb[i] <= (m_h[i] < 640 && m_v[i] < v_act(i)) ? rgb_in : 12'h000;
        if (m_h[i] == 799) begin
          m_h[i] <= 0;
          m_v[i] <= (m_v[i] == v_tot(i) - 1) ? 0 : m_v[i] + 1;
        end else begin
          m_h[i] <= m_h[i] + 1;
        end
      end
    end
  end

  logic [36:0] obs_vec[2];
  assign obs_vec[0] = {b_h, b_v, b_act, b_le, b_fs, b_hs, b_vs, b_r, b_g, b_b};
  assign obs_vec[1] = {s_h, s_v, s_act, s_le, s_fs, s_hs, s_vs, s_r, s_g, s_b};

  function automatic logic [36:0] exp_vec(int i);
    return {10'(m_h[i]), 10'(m_v[i]),
            (m_h[i] < 640 && m_v[i] < v_act(i)), (m_h[i] == 799),
            (m_h[i] == 0 && m_v[i] == 0), m_hs[i], m_vs[i], m_rgb[i]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        if (obs_vec[i] !== exp_vec(i)) mm[i] <= mm[i] + 1;
      end
    end
  end

  int         cyc = 0;
  logic       b_hs_q = 1'b1;
  logic       s_vs_q = 1'b1;
  int         hs_f[$];
  int         hs_r[$];
  int         vs_f[$];
  int         vs_r[$];
  logic [9:0] hs_fh[$];
  logic [9:0] hs_rh[$];
  logic [19:0] vs_fv[$];

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    b_hs_q <= b_hs;
    s_vs_q <= s_vs;
    if (chk_en) begin
      if (b_hs_q && !b_hs && hs_f.size() < 3) begin hs_f.push_back(cyc); hs_fh.push_back(b_h); end
      if (!b_hs_q && b_hs && hs_r.size() < 3) begin hs_r.push_back(cyc); hs_rh.push_back(b_h); end
      if (s_vs_q && !s_vs && vs_f.size() < 2) begin vs_f.push_back(cyc); vs_fv.push_back({s_v, s_h}); end
      if (!s_vs_q && s_vs && vs_r.size() < 1) vs_r.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge clk);
    if (rnd_en) rgb_in = 12'($urandom);
  endtask

  int nb_big  = 0;
  int nb_sml  = 0;
  int nbad    = 0;
  int found   = 0;
  int n_wait  = 0;
  int n_low   = 0;

  initial begin
    repeat (8) @(negedge clk);
    check_result("rst_h_cnt",   32'(b_h), 32'd0);
    check_result("rst_v_cnt",   32'(b_v), 32'd0);
    check_result("rst_hsync",   32'(b_hs), 32'd1);
    check_result("rst_vsync",   32'(b_vs), 32'd1);
    check_result("rst_rgb",     32'({b_r, b_g, b_b}), 32'd0);
    check_result("rst_rgb_sml", 32'({s_r, s_g, s_b}), 32'd0);
    chk_en = 1'b1;
    greset = 1'b0;
    check_result("frame_start_release", 32'(b_fs), 32'd1);

    // One short frame with white input: counts only the unblanked pixels.
    for (int k = 1; k <= 9600; k++) begin
      step();
      if (k == 1) begin
        check_result("first_h_cnt", 32'(b_h), 32'd1);
        check_result("first_rgb",   32'({b_r, b_g, b_b}), 32'hFFF);
        check_result("first_hsync", 32'(b_hs), 32'd1);
      end
      if ({b_r, b_g, b_b} == 12'hFFF) nb_big++;
      else if ({b_r, b_g, b_b} != 12'h000) nbad++;
      if ({s_r, s_g, s_b} == 12'hFFF) nb_sml++;
      else if ({s_r, s_g, s_b} != 12'h000) nbad++;
    end
    check_result("blank_white_big",   32'(nb_big), 32'd7680);
    check_result("blank_white_small", 32'(nb_sml), 32'd3840);
    check_result("blank_other_vals",  32'(nbad),   32'd0);

    rnd_en = 1'b1;
    found = 0;
    for (int n = 0; n < 20000 && found == 0; n++) begin
      if (b_h == 10'd799 && b_v == 10'd20) found = 1; else step();
    end
    check_result("line_wrap_reached", 32'(found), 32'd1);
    step();
    check_result("line_wrap_h", 32'(b_h), 32'd0);
    check_result("line_wrap_v", 32'(b_v), 32'd21);
    check_result("line_wrap_fs", 32'(b_fs), 32'd0);

    found = 0;
    for (int n = 0; n < 20000 && found == 0; n++) begin
      if (s_h == 10'd799 && s_v == 10'd11) found = 1; else step();
    end
    check_result("frame_wrap_reached", 32'(found), 32'd1);
    step();
    check_result("frame_wrap_h",  32'(s_h), 32'd0);
    check_result("frame_wrap_v",  32'(s_v), 32'd0);
    check_result("frame_wrap_fs", 32'(s_fs), 32'd1);

    found = 0;
    for (int n = 0; n < 20000 && found == 0; n++) begin
      if (s_h == 10'd700 && s_v == 10'd3) found = 1; else step();
    end
    check_result("midreset_reached", 32'(found), 32'd1);
    check_result("midreset_pre_hsync", 32'(s_hs), 32'd0);
    greset = 1'b1;
    step();
    check_result("midreset_h",     32'(s_h), 32'd0);
    check_result("midreset_v",     32'(s_v), 32'd0);
    check_result("midreset_hsync", 32'(s_hs), 32'd1);
    check_result("midreset_rgb",   32'({s_r, s_g, s_b}), 32'd0);
    greset = 1'b0;

    n_wait = 0;
    while (s_hs === 1'b1 && n_wait < 2000) begin step(); n_wait++; end
    check_result("restart_hsync_fall", 32'(n_wait), 32'd656);
    n_low = 0;
    while (s_hs === 1'b0 && n_low < 2000) begin step(); n_low++; end
    check_result("restart_hsync_width", 32'(n_low), 32'd96);

    check_result("hs_fall_h_cnt",  32'(hs_fh[0]), 32'd656);
    check_result("hs_rise_h_cnt",  32'(hs_rh[0]), 32'd752);
    check_result("hs_width",       32'(hs_r[0] - hs_f[0]), 32'd96);
    check_result("hs_period_1",    32'(hs_f[1] - hs_f[0]), 32'd800);
    check_result("hs_period_2",    32'(hs_f[2] - hs_f[1]), 32'd800);
    check_result("vs_fall_pos",    32'(vs_fv[0]), 32'({10'd8, 10'd1}));
    check_result("vs_width",       32'(vs_r[0] - vs_f[0]), 32'd1600);
    check_result("vs_fall_to_fall", 32'(vs_f[1] - vs_f[0]), 32'd9600);
    check_result("model_big_cycles_bad",   32'(mm[0]), 32'd0);
    check_result("model_small_cycles_bad", 32'(mm[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
